// File: rtl/axi_ic_pkg.sv
// Shared interconnect types and sizing for the read-response path.
// Master/slave counts, index widths, arbiter state encoding and response codes.
package axi_ic_pkg;
  localparam int M      = 2;
  localparam int S      = 2;
  localparam int MIDX_W = (M > 1) ? $clog2(M) : 1;
  localparam int SIDX_W = (S > 1) ? $clog2(S) : 1;
  localparam int RESP_W = 2;

  typedef enum logic {
    IDLE,
    BURST
  } rr_state_t;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/rd_track_fifo.sv
// In-order tracker of the master index owning each outstanding read at one slave.
// Head is combinational; a push while full is dropped even if a pop occurs that cycle.
module rd_track_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/read_resp_router.sv
// Routes slave R bursts back to the master that issued each read; per-master round-robin, burst-locked.
// Zero-latency combinational forward; a slave stalls while its head master is busy or its tracker is empty.
module read_resp_router
  import axi_ic_pkg::*;
#(
  parameter int NUM_OUTSTANDING_TRANS = 4,
  parameter int ID_WIDTH              = 4,
  parameter int DATA_WIDTH            = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ar_fire,
  input  logic [MIDX_W-1:0]       ar_master,
  input  logic [SIDX_W-1:0]       ar_slave,
  output logic [S-1:0]            ar_ready,
  input  logic [S-1:0]            s_rvalid,
  input  logic [S*DATA_WIDTH-1:0] s_rdata,
  input  logic [S*ID_WIDTH-1:0]   s_rid,
  input  logic [S*RESP_W-1:0]     s_rresp,
  input  logic [S-1:0]            s_rlast,
  output logic [S-1:0]            s_rready,
  output logic [M-1:0]            m_rvalid,
  output logic [M*DATA_WIDTH-1:0] m_rdata,
  output logic [M*ID_WIDTH-1:0]   m_rid,
  output logic [M*RESP_W-1:0]     m_rresp,
  output logic [M-1:0]            m_rlast,
  input  logic [M-1:0]            m_rready,
  output logic                    err_unexpected
);
  localparam int CNT_W = $clog2(NUM_OUTSTANDING_TRANS + 1);

  logic [S-1:0][MIDX_W-1:0] head;
  logic [S-1:0][CNT_W-1:0]  count;
  logic [S-1:0]             empty, full, push, pop, err_set;
  logic [M-1:0][SIDX_W-1:0] sel;
  logic [M-1:0]             sel_vld;

  for (genvar s = 0; s < S; s++) begin : g_slv
    assign push[s]     = ar_fire && (ar_slave == SIDX_W'(s));
    assign pop[s]      = s_rvalid[s] && s_rready[s] && s_rlast[s];
    assign ar_ready[s] = !rst && (count[s] != CNT_W'(NUM_OUTSTANDING_TRANS));
    assign err_set[s]  = (s_rvalid[s] && empty[s]) || (push[s] && full[s]);

    rd_track_fifo #(.WIDTH(MIDX_W), .DEPTH(NUM_OUTSTANDING_TRANS)) u_trk (
      .clk       (clk),
      .rst       (rst),
      .push      (push[s]),
      .push_data (ar_master),
      .pop       (pop[s]),
      .head      (head[s]),
      .count     (count[s]),
      .full      (full[s]),
      .empty     (empty[s])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           err_unexpected <= 1'b0;
    else if (|err_set) err_unexpected <= 1'b1;
  end

  for (genvar m = 0; m < M; m++) begin : g_mst
    rr_state_t         state_q, state_d;
    logic [SIDX_W-1:0] owner_q, owner_d, rr_q, rr_d, sel_c;
    logic              vld_c;
    logic [S-1:0]      req;

    always_comb begin
      req = '0;
      for (int s = 0; s < S; s++)
        req[s] = s_rvalid[s] && !empty[s] && (head[s] == MIDX_W'(m));
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        owner_q <= '0;
        rr_q    <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        rr_q    <= rr_d;
      end
    end

    always_comb begin
      int idx;
      idx     = 0;
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      sel_c   = '0;
      vld_c   = 1'b0;
      case (state_q)
        IDLE: begin
          for (int k = 0; k < S; k++) begin
            idx = (int'(rr_q) + k) % S;
            if (!vld_c && req[idx]) begin
              vld_c = 1'b1;
              sel_c = SIDX_W'(idx);
            end
          end
          if (vld_c && m_rready[m]) begin
            rr_d = SIDX_W'((int'(sel_c) + 1) % S);
            // Multi-beat burst locks this master to the winning slave until RLAST.
            if (!s_rlast[sel_c]) begin
              owner_d = sel_c;
              state_d = BURST;
            end
          end
        end
        BURST: begin
          sel_c = owner_q;
          vld_c = req[owner_q];
          if (vld_c && m_rready[m] && s_rlast[owner_q]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    assign sel[m]     = sel_c;
    assign sel_vld[m] = vld_c;
    assign m_rvalid[m] = vld_c;
    assign m_rdata[m*DATA_WIDTH +: DATA_WIDTH] =
      vld_c ? s_rdata[int'(sel_c)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign m_rid[m*ID_WIDTH +: ID_WIDTH] =
      vld_c ? s_rid[int'(sel_c)*ID_WIDTH +: ID_WIDTH] : '0;
    assign m_rresp[m*RESP_W +: RESP_W] =
      vld_c ? s_rresp[int'(sel_c)*RESP_W +: RESP_W] : '0;
    assign m_rlast[m] = vld_c ? s_rlast[sel_c] : 1'b0;
  end

  // A slave only ever talks to its head master, so each s_rready has a single source.
  always_comb begin
    s_rready = '0;
    for (int s = 0; s < S; s++) begin
      if (!empty[s] && sel_vld[head[s]] && (sel[head[s]] == SIDX_W'(s)))
        s_rready[s] = m_rready[head[s]];
    end
  end
endmodule

// File: tb/tb_read_resp_router.sv
// Directed bench for read_resp_router: routing, arbitration, tracker limits, errors, reset.
module tb_read_resp_router;
  import axi_ic_pkg::*;

  logic            clk, rst, ar_fire;
  logic [MIDX_W-1:0] ar_master;
  logic [SIDX_W-1:0] ar_slave;
  logic [S-1:0]    ar_ready;
  logic [S-1:0]    s_rvalid, s_rlast, s_rready;
  logic [S*32-1:0] s_rdata;
  logic [S*4-1:0]  s_rid;
  logic [S*2-1:0]  s_rresp;
  logic [M-1:0]    m_rvalid, m_rlast, m_rready;
  logic [M*32-1:0] m_rdata;
  logic [M*4-1:0]  m_rid;
  logic [M*2-1:0]  m_rresp;
  logic            err_unexpected;

  int n_chk  = 0;
  int n_pass = 0;

  read_resp_router #(.NUM_OUTSTANDING_TRANS(4), .ID_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ar_fire(ar_fire), .ar_master(ar_master), .ar_slave(ar_slave),
    .ar_ready(ar_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rready(s_rready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rready(m_rready), .err_unexpected(err_unexpected)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    ar_fire   = 1'b0;
    ar_master = '0;
    ar_slave  = '0;
    s_rvalid  = '0;
    s_rlast   = '0;
    s_rdata   = '0;
    s_rid     = '0;
    s_rresp   = '0;
    m_rready  = '1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic ar_push(input int m, input int s);
    ar_fire   = 1'b1;
    ar_master = MIDX_W'(m);
    ar_slave  = SIDX_W'(s);
    @(negedge clk);
    ar_fire = 1'b0;
  endtask

  task automatic beat(input int s, input logic v, input logic [31:0] d,
                      input logic [3:0] id, input logic last);
    s_rvalid[s]       = v;
    s_rdata[s*32 +: 32] = d;
    s_rid[s*4 +: 4]   = id;
    s_rresp[s*2 +: 2] = 2'b00;
    s_rlast[s]        = last;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    s_rvalid = 2'b11;
    #2;
    check("rst_ar_ready", ar_ready, 2'b00);
    check("rst_s_rready", s_rready, 2'b00);
    check("rst_m_rvalid", m_rvalid, 2'b00);
    check("rst_err", err_unexpected, 1'b0);

    // 1: single 4-beat burst S1 -> M0
    do_reset();
    ar_push(0, 1);
    #1 check("t1_ar_ready", ar_ready, 2'b11);
    for (int b = 0; b < 4; b++) begin
      beat(1, 1'b1, 32'hA0 + b, 4'd3, b == 3);
      #1;
      check("t1_m_rvalid", m_rvalid, 2'b01);
      check("t1_m_rdata", m_rdata[31:0], 32'hA0 + b);
      check("t1_m_rid", m_rid[3:0], 4'd3);
      check("t1_m_rlast", m_rlast, {1'b0, b == 3});
      check("t1_s_rready", s_rready, 2'b10);
      @(negedge clk);
    end
    beat(1, 1'b0, 32'h0, 4'd0, 1'b0);
    #1;
    check("t1_count_s1", dut.g_slv[1].u_trk.count, 3'd0);
    check("t1_err", err_unexpected, 1'b0);

    // 2: two slaves return to M0 together; S0 wins, holds until RLAST
    do_reset();
    ar_push(0, 0);
    ar_push(0, 1);
    beat(0, 1'b1, 32'h10, 4'd1, 1'b0);
    beat(1, 1'b1, 32'h20, 4'd2, 1'b0);
    #1;
    check("t2_b0_m_rvalid", m_rvalid, 2'b01);
    check("t2_b0_m_rdata", m_rdata[31:0], 32'h10);
    check("t2_b0_s_rready", s_rready, 2'b01);
    @(negedge clk);
    beat(0, 1'b1, 32'h11, 4'd1, 1'b1);
    #1;
    check("t2_rr_ptr", dut.g_mst[0].rr_q, 1'b1);
    check("t2_b1_m_rdata", m_rdata[31:0], 32'h11);
    check("t2_b1_m_rlast", m_rlast, 2'b01);
    check("t2_b1_s_rready", s_rready, 2'b01);
    @(negedge clk);
    beat(0, 1'b0, 32'h0, 4'd0, 1'b0);
    #1;
    check("t2_b2_m_rdata", m_rdata[31:0], 32'h20);
    check("t2_b2_m_rid", m_rid[3:0], 4'd2);
    check("t2_b2_s_rready", s_rready, 2'b10);
    @(negedge clk);
    beat(1, 1'b1, 32'h21, 4'd2, 1'b1);
    #1;
    check("t2_b3_m_rdata", m_rdata[31:0], 32'h21);
    check("t2_b3_m_rlast", m_rlast, 2'b01);
    @(negedge clk);
    beat(1, 1'b0, 32'h0, 4'd0, 1'b0);
    #1 check("t2_done_m_rvalid", m_rvalid, 2'b00);

    // 3: S0 -> M0 and S1 -> M1 in parallel
    do_reset();
    ar_push(0, 0);
    ar_push(1, 1);
    beat(0, 1'b1, 32'h30, 4'd1, 1'b0);
    beat(1, 1'b1, 32'h40, 4'd2, 1'b0);
    #1;
    check("t3_b0_m_rvalid", m_rvalid, 2'b11);
    check("t3_b0_m_rdata", m_rdata, {32'h40, 32'h30});
    check("t3_b0_m_rid", m_rid, 8'h21);
    check("t3_b0_s_rready", s_rready, 2'b11);
    @(negedge clk);
    beat(0, 1'b1, 32'h31, 4'd1, 1'b1);
    beat(1, 1'b1, 32'h41, 4'd2, 1'b1);
    #1;
    check("t3_b1_m_rdata", m_rdata, {32'h41, 32'h31});
    check("t3_b1_m_rlast", m_rlast, 2'b11);
    @(negedge clk);
    beat(0, 1'b0, 32'h0, 4'd0, 1'b0);
    beat(1, 1'b0, 32'h0, 4'd0, 1'b0);
    #1;
    check("t3_count_s0", dut.g_slv[0].u_trk.count, 3'd0);
    check("t3_count_s1", dut.g_slv[1].u_trk.count, 3'd0);

    // 4: tracker full, overflow, then pop and push together
    do_reset();
    repeat (3) ar_push(0, 0);
    #1 check("t4_ar_ready_3", ar_ready, 2'b11);
    ar_push(0, 0);
    #1;
    check("t4_ar_ready_4", ar_ready, 2'b10);
    check("t4_count_4", dut.g_slv[0].u_trk.count, 3'd4);
    check("t4_err_before", err_unexpected, 1'b0);
    ar_push(0, 0);
    #1;
    check("t4_err_overflow", err_unexpected, 1'b1);
    check("t4_count_ovf", dut.g_slv[0].u_trk.count, 3'd4);
    beat(0, 1'b1, 32'h70, 4'd0, 1'b1);
    #1 check("t4_pop_s_rready", s_rready, 2'b01);
    @(negedge clk);
    beat(0, 1'b0, 32'h0, 4'd0, 1'b0);
    #1;
    check("t4_count_pop", dut.g_slv[0].u_trk.count, 3'd3);
    check("t4_ar_ready_pop", ar_ready, 2'b11);
    ar_fire   = 1'b1;
    ar_master = 1'b1;
    ar_slave  = 1'b0;
    beat(0, 1'b1, 32'h71, 4'd0, 1'b1);
    #1 check("t4_pp_m_rvalid", m_rvalid, 2'b01);
    @(negedge clk);
    ar_fire = 1'b0;
    beat(0, 1'b0, 32'h0, 4'd0, 1'b0);
    #1 check("t4_count_pushpop", dut.g_slv[0].u_trk.count, 3'd3);

    // 5: R from a slave with nothing outstanding
    do_reset();
    beat(1, 1'b1, 32'h88, 4'd3, 1'b1);
    #1;
    check("t5_s_rready", s_rready, 2'b00);
    check("t5_m_rvalid", m_rvalid, 2'b00);
    check("t5_err_same_cycle", err_unexpected, 1'b0);
    @(negedge clk);
    #1 check("t5_err_next", err_unexpected, 1'b1);
    beat(1, 1'b0, 32'h0, 4'd0, 1'b0);

    // 6: reset in the middle of a burst, then a fresh read
    do_reset();
    ar_push(0, 1);
    beat(1, 1'b1, 32'h50, 4'd3, 1'b0);
    #1 check("t6_b0_m_rvalid", m_rvalid, 2'b01);
    @(negedge clk);
    beat(1, 1'b1, 32'h51, 4'd3, 1'b0);
    #1 check("t6_b1_m_rdata", m_rdata[31:0], 32'h51);
    rst = 1'b1;
    #1;
    check("t6_rst_m_rvalid", m_rvalid, 2'b00);
    check("t6_rst_s_rready", s_rready, 2'b00);
    check("t6_rst_ar_ready", ar_ready, 2'b00);
    @(negedge clk);
    beat(1, 1'b0, 32'h0, 4'd0, 1'b0);
    rst = 1'b0;
    #1;
    check("t6_rel_ar_ready", ar_ready, 2'b11);
    check("t6_rel_err", err_unexpected, 1'b0);
    @(negedge clk);
    ar_push(1, 0);
    beat(0, 1'b1, 32'h60, 4'd5, 1'b1);
    #1;
    check("t6_new_m_rvalid", m_rvalid, 2'b10);
    check("t6_new_m_rdata", m_rdata[63:32], 32'h60);
    check("t6_new_m_rid", m_rid[7:4], 4'd5);
    check("t6_new_s_rready", s_rready, 2'b01);
    @(negedge clk);
    beat(0, 1'b0, 32'h0, 4'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
